ahb_arbiter: RTL and testbench

Bus arbiter for the shared AHB address/data path; decides which of NUM_MASTERS masters owns the bus.
- Drives HGRANT, HMASTER and HMASTLOCK.
- Re-arbitrates only at legal points: burst boundaries, lock release, IDLE, or error, retry and split responses.
- Masks split masters until the slave releases them.
- Feeds the master-side mux and the masters' FSM request/grant handshake.

---
 rtl/ahb_pkg.sv | 45 ++++
 rtl/ahb_arb_pick.sv | 42 ++++
 rtl/ahb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ahb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB transfer/burst/response types and arbiter state for the bus arbiter
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } transfer_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } burst_in;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        ARB_FREE   = 2'b00,
        ARB_BURST  = 2'b01,
        ARB_LOCKED = 2'b10
    } arb_state_t;

    // Undefined-length INCR counts as one beat: it may be interrupted at any beat.
    function automatic logic [4:0] burst_beats(burst_in b);
        case (b)
            BURST_WRAP4,  BURST_INCR4:  return 5'd4;
            BURST_WRAP8,  BURST_INCR8:  return 5'd8;
            BURST_WRAP16, BURST_INCR16: return 5'd16;
            default:                    return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// rtl/ahb_arb_pick.sv - combinational priority picker; AHB_ARB_RR_EN selects round-robin from start_i, else lowest index wins
module ahb_arb_pick #(
    parameter int N  = 4,
    parameter int MW = 2
) (
    input  logic [N-1:0]  cand_i,
    input  logic [MW-1:0] start_i,
    output logic [N-1:0]  onehot_o,
    output logic          valid_o
);

    int best;

`ifdef AHB_ARB_RR_EN
    function automatic int prio(int i);
        return (i + N - int'(start_i)) % N;
    endfunction
`else
    logic unused_start;
    assign unused_start = ^start_i;

    function automatic int prio(int i);
        return i;
    endfunction
`endif

    // Smaller prio value wins; ties are impossible since prio is a permutation.
    always_comb begin
        best     = N;
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_i[i] && (prio(i) < best)) begin
                best        = prio(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

    assign valid_o = |cand_i;

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB bus arbiter (HGRANT/HMASTER/HMASTLOCK, split masking); AHB_ARB_RR_EN enables round-robin priority
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 4,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  transfer_t              HTRANS,
    input  burst_in                HBURST,
    input  logic                   HREADY,
    input  resp_t                  HRESP,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK,
    output logic [NUM_MASTERS-1:0] split_mask
);

    localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

    arb_state_t             state_q, state_d;
    logic [4:0]             rem_q, rem_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [MW-1:0]          dmaster_q, dmaster_d;
    logic [NUM_MASTERS-1:0] split_q, split_d;
    logic [MW-1:0]          gidx;
    logic [MW-1:0]          rr_start;
    logic [NUM_MASTERS-1:0] req_oh, free_oh;
    logic                   req_valid, free_valid;

`ifdef AHB_ARB_RR_EN
    logic [MW-1:0] rr_ptr_q, rr_ptr_d;
    assign rr_start = rr_ptr_q;
`else
    assign rr_start = '0;
`endif

    ahb_arb_pick #(.N(NUM_MASTERS), .MW(MW)) u_pick_req (
        .cand_i   (HBUSREQ & ~split_q),
        .start_i  (rr_start),
        .onehot_o (req_oh),
        .valid_o  (req_valid)
    );

    // Fallback when nobody requests and the default master is split-masked.
    ahb_arb_pick #(.N(NUM_MASTERS), .MW(MW)) u_pick_free (
        .cand_i   (~split_q),
        .start_i  ('0),
        .onehot_o (free_oh),
        .valid_o  (free_valid)
    );

    always_comb begin
        gidx = hmaster_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) gidx = MW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        dmaster_d   = dmaster_q;
        split_d     = split_q & ~HSPLIT;
`ifdef AHB_ARB_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        if (!HREADY) begin
            // First cycle of a two-cycle response: abandon the burst now, arbitrate next cycle.
            if (HRESP != RESP_OKAY) begin
                rem_d   = '0;
                state_d = ARB_FREE;
                if (HRESP == RESP_SPLIT) split_d[dmaster_q] = 1'b1;
            end
        end else begin
            case (HTRANS)
                TRANS_NONSEQ: rem_d = burst_beats(HBURST) - 5'd1;
                TRANS_SEQ:    rem_d = (rem_q != 5'd0) ? rem_q - 5'd1 : 5'd0;
                TRANS_BUSY:   rem_d = rem_q;
                default:      rem_d = '0;
            endcase

            if (HRESP != RESP_OKAY) begin
                rem_d   = '0;
                state_d = ARB_FREE;
            end else begin
                case (state_q)
                    ARB_FREE: begin
                        if (HLOCK[hmaster_q] && !split_q[hmaster_q]) state_d = ARB_LOCKED;
                        else if (rem_d > 5'd1)                       state_d = ARB_BURST;
                    end
                    ARB_BURST: begin
                        if (rem_d <= 5'd1) state_d = ARB_FREE;
                    end
                    ARB_LOCKED: begin
                        if (!HLOCK[hmaster_q] && (rem_d <= 5'd1)) state_d = ARB_FREE;
                    end
                    default: state_d = ARB_FREE;
                endcase
            end

            hmaster_d   = gidx;
            hmastlock_d = (|hgrant_q) & HLOCK[gidx];
            dmaster_d   = hmaster_q;

            if (state_d == ARB_FREE) begin
                if (req_valid) begin
                    hgrant_d = req_oh;
`ifdef AHB_ARB_RR_EN
                    // Advance on every grant to a requester so a re-granted owner also rotates away.
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (req_oh[i]) rr_ptr_d = MW'((i + 1) % NUM_MASTERS);
                    end
`endif
                end else if (!split_q[DEFAULT_MASTER]) begin
                    hgrant_d = DEF_OH;
                end else if (free_valid) begin
                    hgrant_d = free_oh;
                end else begin
                    hgrant_d = '0;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ARB_FREE;
            rem_q       <= '0;
            hgrant_q    <= DEF_OH;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            dmaster_q   <= DEF_IDX;
            split_q     <= '0;
`ifdef AHB_ARB_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            dmaster_q   <= dmaster_d;
            split_q     <= split_d;
`ifdef AHB_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign HGRANT     = hgrant_q;
    assign HMASTER    = hmaster_q;
    assign HMASTLOCK  = hmastlock_q;
    assign split_mask = split_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard bench for ahb_arbiter (expectations follow AHB_ARB_RR_EN when defined)
module tb_ahb_arbiter;
    import ahb_pkg::*;

    localparam int F_G = 0;
    localparam int F_M = 1;
    localparam int F_L = 2;
    localparam int F_K = 3;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] HBUSREQ, HLOCK, HSPLIT;
    transfer_t  HTRANS;
    burst_in    HBURST;
    logic       HREADY;
    resp_t      HRESP;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;
    logic [3:0] split_mask;

    typedef struct {
        string       tag;
        int          cyc;
        int          fld;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HBUSREQ    (HBUSREQ),
        .HLOCK      (HLOCK),
        .HTRANS     (HTRANS),
        .HBURST     (HBURST),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HSPLIT     (HSPLIT),
        .HGRANT     (HGRANT),
        .HMASTER    (HMASTER),
        .HMASTLOCK  (HMASTLOCK),
        .split_mask (split_mask)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(int fld);
        case (fld)
            F_G:     return {28'd0, HGRANT};
            F_M:     return {30'd0, HMASTER};
            F_L:     return {31'd0, HMASTLOCK};
            default: return {28'd0, split_mask};
        endcase
    endfunction

    task automatic push(string tag, int fld, logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.cyc = cyc + 1;
        e.fld = fld;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_all(string tag, logic [3:0] g, logic [1:0] m, logic l, logic [3:0] k);
        push({tag, "_grant"}, F_G, {28'd0, g});
        push({tag, "_master"}, F_M, {30'd0, m});
        push({tag, "_lock"}, F_L, {31'd0, l});
        push({tag, "_mask"}, F_K, {28'd0, k});
    endtask

    task automatic tick();
        exp_t e;
        @(posedge HCLK);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.fld), e.val);
        end
    endtask

    task automatic drive(logic [3:0] req, logic [3:0] lock, transfer_t tr, burst_in bu,
                         logic rdy, resp_t rs, logic [3:0] spl);
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = tr;
        HBURST  = bu;
        HREADY  = rdy;
        HRESP   = rs;
        HSPLIT  = spl;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        drive(4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        tick();
        HRESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_exp;

        // Reset values
        HRESET = 1'b1;
        drive(4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        tick();
        push_all("rst", 4'b0001, 2'd0, 1'b0, 4'b0000);
        tick();

        // Reset in the middle of an INCR8 owned by M2
        HRESET = 1'b0;
        drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t1_grant", F_G, 32'h4);
        tick();
        push("t1_master", F_M, 32'd2);
        tick();
        drive(4'b0100, 4'b0000, TRANS_NONSEQ, BURST_INCR8, 1'b1, RESP_OKAY, 4'b0000);
        tick();
        drive(4'b0100, 4'b0000, TRANS_SEQ, BURST_INCR8, 1'b1, RESP_OKAY, 4'b0000);
        push("t1_mid_grant", F_G, 32'h4);
        tick();
        HRESET = 1'b1;
        push_all("t1_rst", 4'b0001, 2'd0, 1'b0, 4'b0000);
        tick();

        // INCR4 by M1, M2 requesting from beat 1
        do_reset();
        drive(4'b0010, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t2_g0", F_G, 32'h2);
        tick();
        push("t2_m0", F_M, 32'd1);
        tick();
        drive(4'b0010, 4'b0000, TRANS_NONSEQ, BURST_INCR4, 1'b1, RESP_OKAY, 4'b0000);
        push("t2_beat0_grant", F_G, 32'h2);
        tick();
        drive(4'b0100, 4'b0000, TRANS_SEQ, BURST_INCR4, 1'b1, RESP_OKAY, 4'b0000);
        push("t2_beat1_grant", F_G, 32'h2);
        tick();
        push("t2_beat2_grant", F_G, 32'h4);
        push("t2_beat2_master", F_M, 32'd1);
        tick();
        push("t2_beat3_master", F_M, 32'd2);
        tick();

        // Locked SINGLE transfers by M0 while M3 requests
        do_reset();
        drive(4'b1001, 4'b0001, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t3_lk_grant", F_G, 32'h1);
        push("t3_lk_lock", F_L, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1001, 4'b0001, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
            push("t3_single_grant", F_G, 32'h1);
            push("t3_single_lock", F_L, 32'd1);
            tick();
        end
        drive(4'b1000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t3_rel_grant", F_G, 32'h8);
        push("t3_rel_lock", F_L, 32'd0);
        tick();
        push("t3_rel_master", F_M, 32'd3);
        tick();

        // SPLIT to M2, then release
        do_reset();
        drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t4_grant", F_G, 32'h4);
        tick();
        push("t4_master", F_M, 32'd2);
        tick();
        drive(4'b0100, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        tick();
        drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b0, RESP_SPLIT, 4'b0000);
        push("t4_c1_mask", F_K, 32'h4);
        push("t4_c1_grant", F_G, 32'h4);
        tick();
        drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_SPLIT, 4'b0000);
        push("t4_c2_grant", F_G, 32'h1);
        push("t4_c2_mask", F_K, 32'h4);
        tick();
        drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t4_masked_grant", F_G, 32'h1);
        tick();
        drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0100);
        push("t4_rel_mask", F_K, 32'h0);
        push("t4_rel_grant", F_G, 32'h1);
        tick();
        drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t4_regrant", F_G, 32'h4);
        tick();

        // Wait states freeze a pending grant change
        do_reset();
        drive(4'b0010, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t5_g", F_G, 32'h2);
        push("t5_m", F_M, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b0, RESP_OKAY, 4'b0000);
            push("t5_wait_grant", F_G, 32'h2);
            push("t5_wait_master", F_M, 32'd0);
            tick();
        end
        drive(4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        push("t5_go_grant", F_G, 32'h4);
        push("t5_go_master", F_M, 32'd1);
        tick();

        // All masters requesting back-to-back SINGLEs
        do_reset();
        for (int k = 0; k < 5; k++) begin
`ifdef AHB_ARB_RR_EN
            rr_exp = 4'b0001 << (k % 4);
`else
            rr_exp = 4'b0001;
`endif
            drive(4'b1111, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
            push("t6_prio_grant", F_G, {28'd0, rr_exp});
            tick();
        end

        drive(4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0000);
        tick();
        check_eq("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
